// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC / fetch controller.
// Included by pc_target_calc and pc_fetch_ctrl.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    EXEC,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } sel_t;

  localparam logic [31:0] PC_INCR = 32'd4;
  localparam int JUMP_HI_BITS = 4;

endpackage

// File: rtl/ShiftLeft2.sv
// Word-to-byte offset scaling (multiply by 4).
// Shared helper used by the branch target path.
module ShiftLeft2 (
  input  logic [31:0] val,
  output logic [31:0] shifted
);

  assign shifted = val << 2;

endmodule

// File: rtl/SignExtend.sv
// Sign-extends a 16-bit immediate to 32 bits.
// Shared helper used by the branch target path.
module SignExtend (
  input  logic [15:0] imm,
  output logic [31:0] ext
);

  assign ext = {{16{imm[15]}}, imm};

endmodule

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: pc+4, branch and jump.
// Fields come from the latched instruction word.
module pc_target_calc
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] index,
  output logic [31:0] pc_plus4,
  output logic [31:0] br_target,
  output logic [31:0] j_target
);

  logic [31:0] offset;
  logic [31:0] offset_sh;

  SignExtend u_sext (
    .imm (index[15:0]),
    .ext (offset)
  );

  ShiftLeft2 u_sl2 (
    .val     (offset),
    .shifted (offset_sh)
  );

  assign pc_plus4  = pc + PC_INCR;
  assign br_target = pc_plus4 + offset_sh;
  assign j_target  = {pc_plus4[31 -: JUMP_HI_BITS],
                      index, 2'b00};

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch sequencer: BOOT/FETCH/EXEC/HALT.
// Optional delay slot via `BRANCH_DELAY_SLOT_EN.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        commit,
  input  logic        is_branch,
  input  logic        branch_cond,
  input  logic        is_jump,
  input  logic        is_jr,
  input  logic [31:0] rs_val,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  state_t      state;
  state_t      state_nxt;
  sel_t        sel;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic [31:0] pc_nxt;
  logic        redirect;
  logic        bad;
  logic        ack_take;
  logic        commit_take;
  logic        halt_take;

`ifdef BRANCH_DELAY_SLOT_EN
  logic        pending_v;
  logic        pending_v_nxt;
  logic [31:0] pending_target;
  logic [31:0] pending_target_nxt;
`endif

  pc_target_calc u_calc (
    .pc        (pc),
    .index     (instr[25:0]),
    .pc_plus4  (pc_plus4),
    .br_target (br_target),
    .j_target  (j_target)
  );

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  // Priority select of the control-transfer source
  always_comb begin
    sel = SEL_SEQ;
    if (is_jr)
      sel = SEL_JR;
    else if (is_jump)
      sel = SEL_J;
    else if (is_branch && branch_cond)
      sel = SEL_BR;
  end

  // Candidate mux and alignment check
  always_comb begin
    target_raw = pc_plus4;
    unique case (sel)
      SEL_SEQ: target_raw = pc_plus4;
      SEL_BR:  target_raw = br_target;
      SEL_J:   target_raw = j_target;
      SEL_JR:  target_raw = rs_val;
      default: target_raw = pc_plus4;
    endcase
    redirect = (sel != SEL_SEQ);
    bad      = CHECK_ALIGN
             && (target_raw[1:0] != 2'b00);
    target   = {target_raw[31:2], 2'b00};
  end

  // Next state and register-update strobes
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ack_take    = 1'b0;
    commit_take = 1'b0;
    halt_take   = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    pending_v_nxt      = pending_v;
    pending_target_nxt = pending_target;
`endif
    unique case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ack_take  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (commit) begin
          commit_take = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
          if (pending_v) begin
            pc_nxt        = pending_target;
            pending_v_nxt = 1'b0;
            state_nxt     = FETCH;
          end else if (redirect && bad) begin
            halt_take = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt    = pc_plus4;
            state_nxt = FETCH;
            if (redirect) begin
              pending_v_nxt      = 1'b1;
              pending_target_nxt = target;
            end
          end
`else
          if (bad) begin
            halt_take = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt    = target;
            state_nxt = FETCH;
          end
`endif
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC and instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      instr        <= '0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pending_v      <= 1'b0;
      pending_target <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (ack_take) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (commit_take) begin
        instr_valid <= 1'b0;
        pc          <= pc_nxt;
      end
      if (halt_take)
        misalign_err <= 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
      pending_v      <= pending_v_nxt;
      pending_target <= pending_target_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: fetch-address scoreboard
// plus direct checks of reset, halt and ignore rules.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        commit;
  logic        is_branch;
  logic        branch_cond;
  logic        is_jump;
  logic        is_jr;
  logic [31:0] rs_val;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_pc;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .commit       (commit),
    .is_branch    (is_branch),
    .branch_cond  (branch_cond),
    .is_jump      (is_jump),
    .is_jr        (is_jr),
    .rs_val       (rs_val),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Wait for a request, pop expected address, compare
  task automatic wait_req(output bit ok);
    int n = 0;
    logic [31:0] e;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = imem_req;
    if (!ok) begin
      check("req_timeout", {31'd0, imem_req}, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("sb_underflow", imem_addr, 32'hxxxx_xxxx);
      return;
    end
    e = exp_q.pop_front();
    check("fetch_addr", imem_addr, e);
    @(negedge clk);
    check("addr_hold", imem_addr, e);
    check("req_hold", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] word,
                       input logic with_commit);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    imem_ack   = 1'b1;
    imem_rdata = word;
    commit     = with_commit;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    commit     = 1'b0;
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, word);
    check("req_low", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic commit_op(input logic jr,
                           input logic jp,
                           input logic br,
                           input logic cond,
                           input logic [31:0] rs,
                           input logic [31:0] nxt,
                           input bit push);
    is_jr       = jr;
    is_jump     = jp;
    is_branch   = br;
    branch_cond = cond;
    rs_val      = rs;
    commit      = 1'b1;
    if (push) exp_q.push_back(nxt);
    @(negedge clk);
    commit      = 1'b0;
    is_jr       = 1'b0;
    is_jump     = 1'b0;
    is_branch   = 1'b0;
    branch_cond = 1'b0;
    rs_val      = 32'h0;
    check("valid_drop", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit saw;
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    commit      = 1'b0;
    is_branch   = 1'b0;
    branch_cond = 1'b0;
    is_jump     = 1'b0;
    is_jr       = 1'b0;
    rs_val      = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_err", {31'd0, misalign_err}, 32'd0);
    reset = 1'b0;
    exp_q.push_back(32'h0);
    fetch(32'h2002_0005, 1'b0);

`ifdef BRANCH_DELAY_SLOT_EN
    commit_op(1, 0, 0, 0, 32'h20, 32'h4, 1);
    fetch(32'h0, 1'b0);
    commit_op(0, 0, 0, 0, 32'h0, 32'h20, 1);
    fetch(32'h1000_0017, 1'b0);
    commit_op(0, 0, 1, 1, 32'h0, 32'h24, 1);
    fetch(32'h0, 1'b0);
    commit_op(1, 0, 0, 0, 32'h300, 32'h80, 1);
    fetch(32'h0, 1'b0);
    check("ds_pc", pc, 32'h80);
    last_pc = 32'h80;
`else
    commit_op(0, 0, 0, 0, 32'h0, 32'h4, 1);
    fetch(32'h0, 1'b0);
    commit_op(1, 0, 0, 0, 32'h40, 32'h40, 1);
    fetch(32'h0, 1'b0);
    check("pc_40", pc, 32'h40);
    check("pc4_44", pc_plus4, 32'h44);
    commit_op(0, 0, 0, 0, 32'h0, 32'h44, 1);
    fetch(32'h0, 1'b0);
    commit_op(1, 0, 0, 0, 32'h100, 32'h100, 1);
    fetch(32'h1000_FFFE, 1'b0);
    commit_op(0, 0, 1, 0, 32'h0, 32'h104, 1);
    fetch(32'h0, 1'b0);
    commit_op(1, 0, 0, 0, 32'h100, 32'h100, 1);
    fetch(32'h1000_FFFE, 1'b0);
    commit_op(0, 0, 1, 1, 32'h0, 32'hFC, 1);
    fetch(32'h0, 1'b0);
    commit_op(1, 1, 1, 1, 32'h800, 32'h800, 1);
    fetch(32'h0, 1'b0);
    commit_op(1, 0, 0, 0, 32'hFFFF_FFFC,
              32'hFFFF_FFFC, 1);
    fetch(32'h0, 1'b0);
    check("wrap_pc4", pc_plus4, 32'h0);
    commit_op(0, 0, 0, 0, 32'h0, 32'h0, 1);
    fetch(32'h0, 1'b0);
    commit_op(1, 0, 0, 0, 32'h1000_0000,
              32'h1000_0000, 1);
    fetch(32'h0800_0010, 1'b0);
    commit_op(0, 1, 1, 1, 32'h0, 32'h1000_0040, 1);
    fetch(32'h1234_5678, 1'b1);
    @(negedge clk);
    check("ack_commit_ign",
          {30'd0, imem_req, instr_valid}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("exec_ack_ign", instr, 32'h1234_5678);
    check("exec_req", {31'd0, imem_req}, 32'd0);
    last_pc = 32'h1000_0040;
`endif

    commit_op(1, 0, 0, 0, 32'h202, 32'h0, 0);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_pc", pc, last_pc);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) saw = 1'b1;
    end
    check("halt_no_req", {31'd0, saw}, 32'd0);
    check("halt_err_hold", {31'd0, misalign_err}, 32'd1);

    reset = 1'b1;
    @(negedge clk);
    check("rst2_err", {31'd0, misalign_err}, 32'd0);
    check("rst2_pc", pc, 32'h0);
    reset = 1'b0;
    exp_q.push_back(32'h0);
    wait_req(ok);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    reset      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    exp_q.push_back(32'h0);
    fetch(32'h0000_1111, 1'b0);
    commit_op(0, 0, 0, 0, 32'h0, 32'h4, 1);
    fetch(32'h0, 1'b0);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
